serial_adder: RTL
=================

// Module: serial_adder
// PURPOSE
//   Parametrised multi-cycle adder/subtractor. Adds or subtracts two WIDTH-bit operands
//   DIGIT bits per clock using a DIGIT-bit ripple of full adders and a carry register.
//   Uses a start/done handshake. Successor to the combinational half/full adders;
//   intended for area-constrained datapaths.
// PARAMETERS
//   WIDTH  8  operand and result width in bits; must be >= 2
//   DIGIT  1  bits processed per cycle; must divide WIDTH. Checked at elaboration; $fatal on violation.
// PORTS
//   clk    in   1      single clock, all state updates on rising edge
//   rst    in   1      synchronous, active-high reset
//   start  in   1      request; sampled only when busy=0
//   sub    in   1      0: a+b+cin; 1: a-b (b inverted, cin forced to 1)
//   a      in   WIDTH  operand A, captured on accepted start
//   b      in   WIDTH  operand B, captured on accepted start
//   cin    in   1      carry in (add mode only), captured on accepted start
//   busy   out  1      1 while computing
//   done   out  1      one-cycle pulse: s/cout/ovf updated this cycle
//   s      out  WIDTH  result, held until next completion
//   cout   out  1      carry out (sub mode: 1 = no borrow)
//   ovf    out  1      two's-complement signed overflow of the completed operation
// BEHAVIOUR
//   - Clock is clk; reset is rst, synchronous, active-high. Reset values:
//     state=IDLE, busy=0, done=0, s=0, cout=0, ovf=0. Internal operand and carry registers are cleared.
//   - States: IDLE, RUN, DONE. N = WIDTH/DIGIT.
//     IDLE --start--> RUN. Capture a, b^{WIDTH{sub}}, carry=sub?1:cin, and set cnt=0.
//     RUN: on each edge, the low DIGIT bits of the operand regs plus carry go through the adder chain.
//       Sum digits shift into the top of the partial register; operands shift right by DIGIT; carry updates; cnt++.
//       The edge that processes digit N-1 moves to DONE and loads s, cout and ovf.
//     DONE: done=1 for exactly this cycle. start accepted here (-> RUN, same capture as IDLE), else -> IDLE.
//   - busy = (state==RUN). done = (state==DONE). Both are registered state decodes with no comb paths.
//   - Latency: start high in cycle 0 -> done high in cycle N+1. Back-to-back throughput is one op per N+1 cycles.
//   - start while busy=1 is ignored. Operand changes during RUN have no effect.
//   - ovf = carry into the MSB XOR carry out of the MSB, taken from the final digit.
//     Expose the MSB-position carry from the chain; valid for DIGIT=1 as well.
//   - s, cout and ovf change only at the RUN->DONE edge or on reset. They hold otherwise, including across idle periods.
//   - Reset mid-RUN aborts: no done pulse, outputs go to reset values, next start behaves normally.
//   - Width rules: the internal carry chain is DIGIT+1 bits. The result register is exactly WIDTH bits, with no truncation loss.
// STRUCTURE
//   - adder_defs.vh (shared include): state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
//     Also holds the counter-width macro used by serial_adder and future multi-cycle arith blocks.
//   - Sub-module: full_adder (a, b, cin -> s, c), instantiated DIGIT times by generate loop.
//   - cnt width = $clog2(N) (minimum 1).
// TESTING  (tb_serial_adder; $dumpfile/$dumpvars; $display with %t; default WIDTH=8, DIGIT=1)
//   1 add carry: a=8'hFF, b=8'h01, cin=0, sub=0, start at cycle 0 -> done at cycle 9, s=8'h00, cout=1, ovf=0.
//   2 subtract borrow: a=8'd5, b=8'd7, sub=1 -> s=8'hFE, cout=0, ovf=0. Then a=8'd7, b=8'd5 -> s=8'h02, cout=1.
//   3 signed overflow: a=8'h7F, b=8'h01 add -> s=8'h80, ovf=1. a=8'h80, b=8'h01 sub -> s=8'h7F, ovf=1.
//   4 handshake: start held high through RUN with changing a/b -> first op's result only.
//     done lasts 1 cycle. A start in the DONE cycle launches the next op with done 9 cycles later.
//   5 reset mid-op: rst at cycle 4 of RUN -> busy=0, s=0, no done pulse. Following op of 8'h12+8'h34 gives s=8'h46.
//   6 random: 20 ops with seed 4045, checked against a+b+cin / a-b golden values, run for DIGIT=1, 2, 4 and WIDTH=16.
//     Latency for each config must be WIDTH/DIGIT+1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the serial adder and later multi-cycle arithmetic blocks:
// the controller state encoding and the digit-counter width helper.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter must still be one bit wide when the whole operand is one digit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full adder; the serial adder chains DIGIT of these per clock.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic c
);
    assign s = a ^ b ^ cin;
    assign c = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: DIGIT bits per clock through a ripple of full adders
// and a carry register. start/done handshake; s, cout and ovf hold between completions.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       dbg_state
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $fatal(1, "serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [DIGIT:0]   chain;
    logic [DIGIT-1:0] sum_dig;
    logic [WIDTH-1:0] sum_ext;

    // chain[DIGIT-1] is the carry into the MSB position of the digit; overflow needs it.
    assign chain[0] = carry_q;
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        full_adder u_fa (
            .a  (a_q[i]),
            .b  (b_q[i]),
            .cin(chain[i]),
            .s  (sum_dig[i]),
            .c  (chain[i+1])
        );
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        sum_ext = '0;
        sum_ext[DIGIT-1:0] = sum_dig;
        case (state_q)
            ST_RUN: begin
                // Sum digits enter at the top so the last digit leaves the result aligned.
                acc_d   = (acc_q >> DIGIT) | (sum_ext << (WIDTH - DIGIT));
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = chain[DIGIT];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                    s_d     = acc_d;
                    cout_d  = chain[DIGIT];
                    ovf_d   = chain[DIGIT] ^ chain[DIGIT-1];
                end
            end
            default: begin
                // IDLE and DONE both accept a new request.
                state_d = ST_IDLE;
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub ? 1'b1 : cin;
                    cnt_d   = '0;
                    acc_d   = '0;
                end
            end
        endcase
        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign dbg_state = state_q;

endmodule
